// File: rtl/sysid_probe_master_if.sv
// rtl/sysid_probe_master_if.sv - Avalon-MM read channel between the probe master and the system-ID slave
interface sysid_probe_master_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sysid_probe_master.sv
// rtl/sysid_probe_master.sv - reads system ID and build timestamp once per probe and checks them against expected values
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1668672546,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  sysid_probe_master_if.master        avm,
  output logic [31:0]                 id_value,
  output logic [31:0]                 ts_value,
  output logic                        busy,
  output logic                        done,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_ID,
    S_WAIT_ID,
    S_REQ_TS,
    S_WAIT_TS,
    S_DONE
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        auto_q, auto_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_err_q, tmo_err_d;
  logic        tmo_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= 8'd0;
      auto_q    <= AUTO_START;
      id_q      <= 32'd0;
      ts_q      <= 32'd0;
      id_ok_q   <= 1'b0;
      ts_ok_q   <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      auto_q    <= auto_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      id_ok_q   <= id_ok_d;
      ts_ok_q   <= ts_ok_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // >= rather than == so a command accepted on the last budget cycle cannot let the counter run past the limit
  assign tmo_hit = (tmo_q >= TMO_LAST);

  always_comb begin
    state_d         = state_q;
    tmo_d           = tmo_q;
    auto_d          = auto_q;
    id_d            = id_q;
    ts_d            = ts_q;
    id_ok_d         = id_ok_q;
    ts_ok_d         = ts_ok_q;
    tmo_err_d       = tmo_err_q;
    avm.avm_read    = 1'b0;
    avm.avm_address = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start || (state_q == S_IDLE && auto_q)) begin
          state_d   = S_REQ_ID;
          auto_d    = 1'b0;
          tmo_d     = 8'd0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          tmo_err_d = 1'b0;
        end
      end

      S_REQ_ID: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = 1'b0;
        tmo_d           = tmo_q + 8'd1;
        if (!avm.avm_waitrequest) begin
          state_d = S_WAIT_ID;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end

      S_WAIT_ID: begin
        tmo_d = tmo_q + 8'd1;
        if (avm.avm_readdatavalid) begin
          id_d    = avm.avm_readdata;
          state_d = S_REQ_TS;
          tmo_d   = 8'd0;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end

      S_REQ_TS: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = 1'b1;
        tmo_d           = tmo_q + 8'd1;
        if (!avm.avm_waitrequest) begin
          state_d = S_WAIT_TS;
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end

      S_WAIT_TS: begin
        tmo_d = tmo_q + 8'd1;
        if (avm.avm_readdatavalid) begin
          ts_d    = avm.avm_readdata;
          state_d = S_DONE;
          // compare the fresh word directly so ts_ok is valid in the same cycle done rises
          id_ok_d = (id_q == EXPECTED_ID);
          ts_ok_d = (avm.avm_readdata == EXPECTED_TS);
        end else if (tmo_hit) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// tb/tb_sysid_probe_master.sv - scoreboard bench for sysid_probe_master with a randomized Avalon slave
module tb_sysid_probe_master;
  localparam int          T      = 8;
  localparam int          NEVER  = 255;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1668672546;

  typedef struct {
    logic [31:0] id;
    logic [31:0] ts;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    int          done_cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] id_value, ts_value;
  logic        busy, done, id_ok, ts_ok, timeout_err;

  sysid_probe_master_if bus();

  sysid_probe_master #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(T),
    .AUTO_START    (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .avm        (bus.master),
    .id_value   (id_value),
    .ts_value   (ts_value),
    .busy       (busy),
    .done       (done),
    .id_ok      (id_ok),
    .ts_ok      (ts_ok),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  exp_t        sb[$];
  int          w[2];
  int          lat[2];
  logic [31:0] dat[2];
  bit          zl[2];
  bit          stray = 1'b0;
  logic        exp_addr = 1'b0;
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_cfg(input int w0, input int l0, input int w1, input int l1,
                         input logic [31:0] d0, input logic [31:0] d1, input bit z0, input bit z1);
    w[0] = w0; lat[0] = l0; dat[0] = d0; zl[0] = z0;
    w[1] = w1; lat[1] = l1; dat[1] = d1; zl[1] = z1;
  endtask

  // Reference: each read costs waits + latency + 1 cycles, or the whole budget if it does not finish in time
  task automatic model_push(input int s);
    exp_t e;
    int   dur;
    bit   to;
    dur = 0;
    to  = 1'b0;
    for (int a = 0; a < 2 && !to; a++) begin
      if (w[a] >= T || lat[a] >= NEVER || w[a] + lat[a] > T - 1) begin
        dur += T;
        to = 1'b1;
      end else begin
        dur += w[a] + lat[a] + 1;
        if (a == 0) m_id = dat[0];
        else        m_ts = dat[1];
      end
    end
    e.id       = m_id;
    e.ts       = m_ts;
    e.tmo      = to;
    e.id_ok    = !to && (m_id == EXP_ID);
    e.ts_ok    = !to && (m_ts == EXP_TS);
    e.done_cyc = s + dur;
    sb.push_back(e);
  endtask

  // Slave: sample the bus at negedge, drive the next cycle just after posedge
  initial begin
    logic s_rd, s_wr, s_addr, pend, pend_addr, cur_a;
    bit   in_wait;
    int   lcnt, req_cnt;
    pend = 1'b0; pend_addr = 1'b0; cur_a = 1'b0;
    in_wait = 1'b0; lcnt = 0; req_cnt = 0;
    bus.avm_waitrequest   = 1'b1;
    bus.avm_readdata      = 32'd0;
    bus.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clock);
      s_rd   = bus.avm_read;
      s_addr = bus.avm_address;
      s_wr   = bus.avm_waitrequest;
      if (s_rd && pend && !reset) chk("addr_stable", {31'd0, s_addr}, {31'd0, pend_addr});
      pend      = s_rd && s_wr;
      pend_addr = s_addr;
      @(posedge clock);
      #1;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = $urandom;
      if (reset) begin
        in_wait = 1'b0;
        pend    = 1'b0;
      end else begin
        if (s_rd && !s_wr) begin
          chk("addr_order", {31'd0, s_addr}, {31'd0, exp_addr});
          exp_addr = 1'b1;
          in_wait  = 1'b1;
          lcnt     = 0;
          cur_a    = s_addr;
        end
        if (in_wait) begin
          lcnt++;
          if (lcnt == lat[cur_a]) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = dat[cur_a];
            in_wait = 1'b0;
          end else if (lcnt > T + 4) begin
            in_wait = 1'b0;
          end
        end
      end
      if (!reset && bus.avm_read) begin
        req_cnt = pend ? req_cnt + 1 : 0;
        bus.avm_waitrequest = (req_cnt < w[bus.avm_address]);
        if (!bus.avm_waitrequest && zl[bus.avm_address]) begin
          bus.avm_readdatavalid = 1'b1;
          bus.avm_readdata      = ~dat[bus.avm_address];
        end else if (bus.avm_waitrequest && stray) begin
          bus.avm_readdatavalid = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
        if (!bus.avm_readdatavalid && !in_wait && !busy && stray)
          bus.avm_readdatavalid = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: every rising edge of done retires one scoreboard entry
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done rose at cycle %0d with no probe outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk("id_value",    id_value, e.id);
          chk("ts_value",    ts_value, e.ts);
          chk("id_ok",       {31'd0, id_ok}, {31'd0, e.id_ok});
          chk("ts_ok",       {31'd0, ts_ok}, {31'd0, e.ts_ok});
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("done_cycle",  32'(cyc), 32'(e.done_cyc));
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s_complete: probe still outstanding after %0d cycles, expected done", tag, n);
      sb.delete();
    end
    repeat (10) @(posedge clock);
  endtask

  task automatic start_probe(input string tag);
    @(posedge clock);
    #1;
    exp_addr = 1'b0;
    start    = 1'b1;
    model_push(cyc + 1);
    @(posedge clock);
    #1;
    start = 1'b0;
    chk({tag, "_clr_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_clr_idok"},  {31'd0, id_ok}, 32'd0);
    chk({tag, "_clr_tsok"},  {31'd0, ts_ok}, 32'd0);
    chk({tag, "_clr_tmo"},   {31'd0, timeout_err}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy}, 32'd1);
  endtask

  task automatic run_probe(input string tag, input int busy_pulse);
    start_probe(tag);
    if (busy_pulse > 0) begin
      repeat (busy_pulse) @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    wait_idle(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_avm_read"}, {31'd0, bus.avm_read}, 32'd0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, done}, 32'd0);
    chk({tag, "_flags"},    {29'd0, id_ok, ts_ok, timeout_err}, 32'd0);
  endtask

  task automatic reset_mid(input string tag, input int w0, input int l0, input bit in_req);
    set_cfg(w0, l0, 0, 1, 32'hCAFE_0001, EXP_TS, 1'b0, 1'b0);
    start_probe(tag);
    @(posedge clock);
    #2;
    if (in_req) chk({tag, "_read_before"}, {31'd0, bus.avm_read}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero(tag);
    sb.delete();
    m_id = 32'd0;
    m_ts = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    set_cfg(0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    exp_addr = 1'b0;
    reset    = 1'b0;
    model_push(cyc + 1);
    wait_idle({tag, "_auto"});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, w0, w1, l0, l1, bp;
    logic [31:0] d0, d1;
    bit          z0, z1;

    set_cfg(0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    model_push(cyc + 1);
    wait_idle("auto_start");

    set_cfg(0, 1, 0, 1, 32'h1234_5678, EXP_TS, 1'b0, 1'b0);
    run_probe("bad_id", 0);
    set_cfg(3, 1, 3, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("wait3", 0);
    set_cfg(0, 1, 0, NEVER, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("ts_timeout", 0);
    set_cfg(0, 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("busy_start", 2);
    set_cfg(0, T - 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("edge_ok", 0);
    set_cfg(0, T, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("edge_late", 0);
    set_cfg(T + 2, 1, 0, 1, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_probe("req_timeout", 0);
    set_cfg(0, 2, 0, 1, EXP_ID, 32'hDEAD_BEEF, 1'b1, 1'b1);
    run_probe("zero_lat", 0);

    reset_mid("rst_wait_id", 0, 5, 1'b0);
    reset_mid("rst_req_id", 3, 1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      w0   = $urandom_range(0, 3);
      w1   = $urandom_range(0, 3);
      l0   = $urandom_range(1, T - 1 - w0);
      l1   = $urandom_range(1, T - 1 - w1);
      d0   = $urandom_range(0, 1) ? EXP_ID : $urandom;
      d1   = $urandom_range(0, 1) ? EXP_TS : $urandom;
      z0   = ($urandom_range(0, 3) == 0);
      z1   = ($urandom_range(0, 3) == 0);
      bp   = 0;
      if (kind == 0) w0 = T + $urandom_range(0, 3);
      if (kind == 1) l1 = NEVER;
      if (kind == 2) l0 = T - w0 + $urandom_range(0, 2);
      if (kind == 3) l1 = T - 1 - w1;
      if (kind == 4) bp = $urandom_range(1, 2);
      if (kind == 5) w1 = T + $urandom_range(0, 3);
      stray = 1'($urandom_range(0, 1));
      set_cfg(w0, l0, w1, l1, d0, d1, z0, z1);
      run_probe("rand", bp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
